// File: rtl/write_back_pipe_if.sv
// write_back_pipe_if
//   Bundles the dual-pipe result inputs, flush, and the register-file write
//   ports / status outputs of write_back_pipe.
//   master : producer side (execution units / bench) drives results and flush,
//            observes write ports and status.
//   slave  : write_back_pipe itself.
//   Parameter LAT_W is the width of the latency fields.
interface write_back_pipe_if #(
  parameter int LAT_W = 3
);
  logic             ep_result_valid;
  logic [6:0]       ep_result_rt;
  logic [127:0]     ep_result_value;
  logic [LAT_W-1:0] ep_result_latency;
  logic             op_result_valid;
  logic [6:0]       op_result_rt;
  logic [127:0]     op_result_value;
  logic [LAT_W-1:0] op_result_latency;
  logic             flush;

  logic             wrt_en_ep;
  logic [6:0]       rt_ep_address;
  logic [127:0]     rt_value_ep;
  logic             wrt_en_op;
  logic [6:0]       rt_op_address;
  logic [127:0]     rt_value_op;
  logic             wb_collision;
  logic [1:0]       slot_conflict;
  logic [1:0]       illegal_latency;
  logic [15:0]      collision_count;

  modport master (
    output ep_result_valid, ep_result_rt, ep_result_value, ep_result_latency,
    output op_result_valid, op_result_rt, op_result_value, op_result_latency,
    output flush,
    input  wrt_en_ep, rt_ep_address, rt_value_ep,
    input  wrt_en_op, rt_op_address, rt_value_op,
    input  wb_collision, slot_conflict, illegal_latency, collision_count
  );

  modport slave (
    input  ep_result_valid, ep_result_rt, ep_result_value, ep_result_latency,
    input  op_result_valid, op_result_rt, op_result_value, op_result_latency,
    input  flush,
    output wrt_en_ep, rt_ep_address, rt_value_ep,
    output wrt_en_op, rt_op_address, rt_value_op,
    output wb_collision, slot_conflict, illegal_latency, collision_count
  );
endinterface

// File: rtl/write_back_pipe.sv
// write_back_pipe
//   Aligns even- and odd-pipe results of differing latency to a common retire
//   stage (stage DEPTH) and drives the two register-file write ports. A result
//   with latency L is inserted directly into stage L; every stage shifts one
//   step per cycle. Same-cycle writes to one RT are resolved in favour of the
//   odd pipe.
//   Ports:
//     clock  rising-edge clock
//     reset  synchronous active-high, clears all valid bits, pulses and counter
//     bus    write_back_pipe_if.slave: result inputs, flush, write ports,
//            wb_collision, slot_conflict, illegal_latency, collision_count
module write_back_pipe #(
  parameter int DEPTH = 7,
  parameter int LAT_W = 3
) (
  input logic              clock,
  input logic              reset,
  write_back_pipe_if.slave bus
);

  // Index 0 is the even pipe, index 1 the odd pipe throughout.
  logic [DEPTH:1]   valid_r [2];
  logic [6:0]       rt_r    [2][1:DEPTH];
  logic [127:0]     value_r [2][1:DEPTH];
  logic [1:0]       conflict_r;
  logic [1:0]       illegal_r;
  logic [15:0]      count_r;

  logic [1:0]       in_valid_s;
  logic [6:0]       in_rt_s    [2];
  logic [127:0]     in_value_s [2];
  logic [LAT_W-1:0] in_lat_s   [2];
  logic [1:0]       legal_s;
  logic [1:0]       insert_s;
  logic [1:0]       conflict_s;
  logic [1:0]       illegal_s;
  logic             ep_ret_s;
  logic             op_ret_s;
  logic             collision_s;
  logic             en_ep_s;
  logic [15:0]      count_next_s;

  // Gather both pipes' inputs into indexable arrays.
  always_comb begin
    in_valid_s    = {bus.op_result_valid, bus.ep_result_valid};
    in_rt_s[0]    = bus.ep_result_rt;
    in_rt_s[1]    = bus.op_result_rt;
    in_value_s[0] = bus.ep_result_value;
    in_value_s[1] = bus.op_result_value;
    in_lat_s[0]   = bus.ep_result_latency;
    in_lat_s[1]   = bus.op_result_latency;
  end

  // Latency legality, insertion qualification and overwrite detection.
  always_comb begin
    legal_s    = 2'b00;
    insert_s   = 2'b00;
    conflict_s = 2'b00;
    illegal_s  = 2'b00;
    for (int p = 0; p < 2; p++) begin
      legal_s[p]   = (in_lat_s[p] != '0) && (int'(in_lat_s[p]) <= DEPTH);
      // Flush swallows same-cycle results silently, including illegal ones.
      insert_s[p]  = !bus.flush && in_valid_s[p] && legal_s[p];
      illegal_s[p] = !bus.flush && in_valid_s[p] && !legal_s[p];
      // Stage 1 has no shift source, so only stages 2..DEPTH can conflict.
      for (int k = 2; k <= DEPTH; k++) begin
        conflict_s[p] = conflict_s[p] |
                        (insert_s[p] && (int'(in_lat_s[p]) == k) && valid_r[p][k-1]);
      end
    end
  end

  // Retire stage decode and collision resolution (odd pipe wins).
  always_comb begin
    ep_ret_s    = valid_r[0][DEPTH];
    op_ret_s    = valid_r[1][DEPTH];
    collision_s = ep_ret_s && op_ret_s && (rt_r[0][DEPTH] == rt_r[1][DEPTH]);
    en_ep_s     = ep_ret_s && !collision_s;
    // The count output includes the collision being reported this cycle.
    if (collision_s && (count_r != 16'hFFFF)) begin
      count_next_s = count_r + 16'd1;
    end else begin
      count_next_s = count_r;
    end
  end

  // Stage shift/insert, status pulses and collision counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        valid_r[p] <= '0;
      end
      conflict_r <= 2'b00;
      illegal_r  <= 2'b00;
      count_r    <= 16'h0000;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (insert_s[p] && (int'(in_lat_s[p]) == 1)) begin
          valid_r[p][1] <= 1'b1;
          rt_r[p][1]    <= in_rt_s[p];
          value_r[p][1] <= in_value_s[p];
        end else begin
          valid_r[p][1] <= 1'b0;
        end
        for (int k = 2; k <= DEPTH; k++) begin
          if (insert_s[p] && (int'(in_lat_s[p]) == k)) begin
            valid_r[p][k] <= 1'b1;
            rt_r[p][k]    <= in_rt_s[p];
            value_r[p][k] <= in_value_s[p];
          end else begin
            valid_r[p][k] <= valid_r[p][k-1] & ~bus.flush;
            rt_r[p][k]    <= rt_r[p][k-1];
            value_r[p][k] <= value_r[p][k-1];
          end
        end
      end
      conflict_r <= conflict_s;
      illegal_r  <= illegal_s;
      count_r    <= count_next_s;
    end
  end

  assign bus.wrt_en_ep       = en_ep_s;
  assign bus.rt_ep_address   = en_ep_s ? rt_r[0][DEPTH] : 7'd0;
  assign bus.rt_value_ep     = en_ep_s ? value_r[0][DEPTH] : 128'd0;
  assign bus.wrt_en_op       = op_ret_s;
  assign bus.rt_op_address   = op_ret_s ? rt_r[1][DEPTH] : 7'd0;
  assign bus.rt_value_op     = op_ret_s ? value_r[1][DEPTH] : 128'd0;
  assign bus.wb_collision    = collision_s;
  assign bus.slot_conflict   = conflict_r;
  assign bus.illegal_latency = illegal_r;
  assign bus.collision_count = count_next_s;

endmodule
